// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, default multiplier settle time and
// the state encoding of the multi-cycle multiplier issue stage.
package alu_pkg;
   localparam int ALU_WIDTH          = 16;
   localparam int MUL_SETTLE_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } mul_state_t;
endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with zero detect, used to time multi-cycle ALU ops.
// Load has priority over decrement; decrement stops at zero.
module settle_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/capture stage around the combinational multiplier: holds operands
// steady for SETTLE_CYC cycles, captures the product, then hands it downstream.
module mul_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH      = ALU_WIDTH,
   parameter int SETTLE_CYC = MUL_SETTLE_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   output logic             mul_cin,
   input  logic [WIDTH-1:0] mul_s,
   input  logic             mul_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             busy
);

   localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYC - 1);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic             mul_cin_q, mul_cin_d;
   logic [WIDTH-1:0] out_s_q, out_s_d;
   logic             out_ovf_q, out_ovf_d;
   logic             out_zero_q, out_zero_d;

   logic             accept;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [3:0]       cnt_val;

   settle_counter #(.CNT_W(4)) u_settle_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (LOAD_VAL),
      .cnt_o      (cnt_val),
      .zero_o     (cnt_zero)
   );

   // Accepting from DONE retires the held result on the same edge.
   assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d    = state_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      mul_cin_d  = mul_cin_q;
      out_s_d    = out_s_q;
      out_ovf_d  = out_ovf_q;
      out_zero_d = out_zero_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      if (accept) begin
         mul_a_d   = in_a;
         mul_b_d   = in_b;
         mul_cin_d = in_cin;
         cnt_load  = 1'b1;
         state_d   = SETTLE;
      end else begin
         unique case (state_q)
            SETTLE: begin
               if (cnt_zero) begin
                  out_s_d    = mul_s;
                  out_ovf_d  = mul_cout;
                  out_zero_d = (mul_s == '0);
                  state_d    = DONE;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         mul_cin_q  <= 1'b0;
         out_s_q    <= '0;
         out_ovf_q  <= 1'b0;
         out_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         mul_cin_q  <= mul_cin_d;
         out_s_q    <= out_s_d;
         out_ovf_q  <= out_ovf_d;
         out_zero_q <= out_zero_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_cin   = mul_cin_q;
   assign out_s     = out_s_q;
   assign out_ovf   = out_ovf_q;
   assign out_zero  = out_zero_q;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

   logic unused_cnt;
   assign unused_cnt = ^cnt_val;

endmodule
